// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction memory address, tracks the
// one-cycle read latency and fills the IF/ID register. Optional halt on opcode F: FETCH_HALT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal fetch: sequential advance, stall rewind, redirect
// HALTED  | fetch frozen after an opcode-F instruction (FETCH_HALT_EN)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    input  logic [15:0] instruction_in,
    output logic [15:0] read_address,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [15:0] fetch_count,
    output logic        halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]  state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] inflight_pc;
    logic        inflight_valid, inflight_valid_nxt;
    logic [15:0] ifid_pc_nxt;
    logic [15:0] ifid_instr_nxt;
    logic        ifid_valid_nxt;
    logic [15:0] count_nxt;
    logic        halt_hit;

    // Opcode F only ends fetch when the halt feature is built in.
`ifdef FETCH_HALT_EN
    assign halt_hit = inflight_valid && (instruction_in[15:12] == 4'hF);
`else
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        inflight_valid_nxt = inflight_valid;
        ifid_pc_nxt        = if_id_pc;
        ifid_instr_nxt     = if_id_instruction;
        ifid_valid_nxt     = if_id_valid;
        count_nxt          = fetch_count;

        if (redirect) begin
            state_nxt          = ST_RUN;
            pc_nxt             = redirect_target;
            inflight_valid_nxt = 1'b0;
            ifid_pc_nxt        = 16'h0000;
            ifid_instr_nxt     = NOP_WORD;
            ifid_valid_nxt     = 1'b0;
        end else if (state == ST_HALTED) begin
            inflight_valid_nxt = 1'b0;
            ifid_pc_nxt        = 16'h0000;
            ifid_instr_nxt     = NOP_WORD;
            ifid_valid_nxt     = 1'b0;
        end else if (stall) begin
            // Rewind to the pending address so the in-flight word is refetched, not lost.
            if (inflight_valid) begin
                pc_nxt             = inflight_pc;
                inflight_valid_nxt = 1'b0;
            end else begin
                inflight_valid_nxt = 1'b1;
            end
        end else begin
            ifid_pc_nxt        = inflight_pc;
            ifid_instr_nxt     = inflight_valid ? instruction_in : NOP_WORD;
            ifid_valid_nxt     = inflight_valid;
            pc_nxt             = pc + PC_STEP;
            inflight_valid_nxt = 1'b1;
            if (inflight_valid) begin
                count_nxt = fetch_count + 16'd1;
            end
            if (halt_hit) begin
                state_nxt          = ST_HALTED;
                inflight_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_RUN;
            pc                <= RESET_PC;
            inflight_pc       <= 16'h0000;
            inflight_valid    <= 1'b0;
            if_id_pc          <= 16'h0000;
            if_id_instruction <= NOP_WORD;
            if_id_valid       <= 1'b0;
            fetch_count       <= 16'h0000;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            inflight_pc       <= pc;
            inflight_valid    <= inflight_valid_nxt;
            if_id_pc          <= ifid_pc_nxt;
            if_id_instruction <= ifid_instr_nxt;
            if_id_valid       <= ifid_valid_nxt;
            fetch_count       <= count_nxt;
        end
    end

    assign read_address = pc;

`ifdef FETCH_HALT_EN
    assign halted = (state == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered instruction-memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic [15:0] instruction_in = 16'h0000;
    logic [15:0] read_address;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_instruction;
    logic        if_id_valid;
    logic [15:0] fetch_count;
    logic        halted;
    logic        halt_mode = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .instruction_in(instruction_in),
        .read_address(read_address),
        .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_valid(if_id_valid),
        .fetch_count(fetch_count),
        .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0000: mem_rd = 16'h1010;
            16'h0002: mem_rd = halt_mode ? 16'hF000 : 16'h1231;
            16'h0004: mem_rd = 16'h145e;
            16'h0006: mem_rd = 16'h167f;
            16'h0008: mem_rd = 16'hF123;
            16'hFFFE: mem_rd = 16'h2222;
            default:  mem_rd = 16'h0000;
        endcase
    endfunction

    always @(posedge clk) instruction_in <= mem_rd(read_address);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [15:0] p, input logic [15:0] i);
        chk({tag, ".valid"}, {15'd0, if_id_valid}, 16'd1);
        chk({tag, ".pc"}, if_id_pc, p);
        chk({tag, ".instr"}, if_id_instruction, i);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 16'h0000;
        step();
        chk("rst.ra", read_address, 16'h0000);
        chk("rst.valid", {15'd0, if_id_valid}, 16'd0);
        chk("rst.instr", if_id_instruction, 16'h0000);
        chk("rst.count", fetch_count, 16'd0);
        chk("rst.halted", {15'd0, halted}, 16'd0);
        rst = 1'b1;
    endtask

    initial begin
        // sequential run
        do_reset();
        step(); chk("seq.e1.valid", {15'd0, if_id_valid}, 16'd0); chk("seq.e1.ra", read_address, 16'h0002);
        step(); ifid("seq.e2", 16'h0000, 16'h1010); chk("seq.e2.ra", read_address, 16'h0004);
        step(); ifid("seq.e3", 16'h0002, 16'h1231); chk("seq.e3.ra", read_address, 16'h0006);
        step(); ifid("seq.e4", 16'h0004, 16'h145e); chk("seq.e4.ra", read_address, 16'h0008);
        step(); ifid("seq.e5", 16'h0006, 16'h167f); chk("seq.count", fetch_count, 16'd4);
`ifndef FETCH_HALT_EN
        step(); ifid("seq.opF", 16'h0008, 16'hF123);
        chk("seq.opF.halted", {15'd0, halted}, 16'd0);
        chk("seq.opF.count", fetch_count, 16'd5);
`endif

        // three-cycle stall while IF/ID holds PC 2
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); ifid("stall.hold", 16'h0002, 16'h1231);
        end
        chk("stall.count", fetch_count, 16'd2);
        stall = 1'b0;
        step(); chk("stall.bubble", {15'd0, if_id_valid}, 16'd0);
        step(); ifid("stall.next4", 16'h0004, 16'h145e);
        step(); ifid("stall.next6", 16'h0006, 16'h167f);
        chk("stall.count2", fetch_count, 16'd4);

        // redirect to 0 while IF/ID holds PC 4
        do_reset();
        step(); step(); step(); step();
        redirect = 1'b1; redirect_target = 16'h0000;
        step();
        chk("redir.valid", {15'd0, if_id_valid}, 16'd0);
        chk("redir.instr", if_id_instruction, 16'h0000);
        chk("redir.ra", read_address, 16'h0000);
        redirect = 1'b0;
        step(); chk("redir.bubble2", {15'd0, if_id_valid}, 16'd0);
        step(); ifid("redir.refetch", 16'h0000, 16'h1010);
        chk("redir.count", fetch_count, 16'd4);

        // redirect beats stall
        do_reset();
        step(); step(); step();
        redirect = 1'b1; stall = 1'b1; redirect_target = 16'h0004;
        step();
        chk("both.valid", {15'd0, if_id_valid}, 16'd0);
        chk("both.ra", read_address, 16'h0004);
        redirect = 1'b0; stall = 1'b0;
        step(); chk("both.bubble2", {15'd0, if_id_valid}, 16'd0);
        step(); ifid("both.fetch4", 16'h0004, 16'h145e);

        // PC wrap at the top of the address space
        do_reset();
        step(); step();
        redirect = 1'b1; redirect_target = 16'hFFFE;
        step(); chk("wrap.ra0", read_address, 16'hFFFE);
        redirect = 1'b0;
        step(); chk("wrap.ra1", read_address, 16'h0000);
        step(); ifid("wrap.fetch", 16'hFFFE, 16'h2222); chk("wrap.ra2", read_address, 16'h0002);

        // asynchronous reset mid-stream
        do_reset();
        step(); step(); step();
        chk("mid.pre.ra", read_address, 16'h0006);
        rst = 1'b0;
        #1;
        chk("mid.ra", read_address, 16'h0000);
        chk("mid.valid", {15'd0, if_id_valid}, 16'd0);
        chk("mid.pc", if_id_pc, 16'h0000);
        chk("mid.count", fetch_count, 16'd0);
        step();
        rst = 1'b1;
        step(); chk("mid.e1.valid", {15'd0, if_id_valid}, 16'd0);
        step(); ifid("mid.refetch", 16'h0000, 16'h1010);
        chk("mid.count2", fetch_count, 16'd1);

`ifdef FETCH_HALT_EN
        halt_mode = 1'b1;
        do_reset();
        step(); step();
        step(); ifid("halt.F000", 16'h0002, 16'hF000);
        chk("halt.flag", {15'd0, halted}, 16'd1);
        chk("halt.ra", read_address, 16'h0006);
        stall = 1'b1;
        step();
        chk("halt.bubble", {15'd0, if_id_valid}, 16'd0);
        chk("halt.ra2", read_address, 16'h0006);
        chk("halt.count", fetch_count, 16'd2);
        stall = 1'b0;
        redirect = 1'b1; redirect_target = 16'h0000;
        step();
        chk("halt.release", {15'd0, halted}, 16'd0);
        redirect = 1'b0;
        halt_mode = 1'b0;
        step();
        step(); ifid("halt.resume", 16'h0000, 16'h1010);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Drives the instruction memory address each cycle and tracks the one-cycle registered read latency.
- Captures returned instructions into the IF/ID pipeline register.
- Handles stall (rewind-and-refetch), branch/jump redirect with flush, and sequential PC advance.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, PC increment per sequential fetch (instructions sit at even addresses).
NOP_WORD, 16'h0000, value driven on if_id_instruction for bubbles and flushes.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
stall  input  1  decode hazard; IF/ID must hold its contents this cycle.
redirect  input  1  branch/jump taken; flush the pipe and refetch from redirect_target.
redirect_target  input  16  new PC when redirect=1.
instruction_in  input  16  instruction memory data; equals mem[address issued in the previous cycle].
read_address  output  16  instruction memory address (the PC register).
if_id_pc  output  16  PC of the instruction held in IF/ID.
if_id_instruction  output  16  instruction held in IF/ID; format {opcode[15:12], op1[11:8], op2[7:4], funct[3:0]}.
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
fetch_count  output  16  count of instructions written into IF/ID with valid=1; wraps at 16'hFFFF.
halted  output  1  fetch stopped (meaningful only with FETCH_HALT_EN).

Behaviour:
- Reset (rst=0, asynchronous) values:
  - pc=RESET_PC.
  - inflight_pc=0, inflight_valid=0.
  - if_id_pc=0, if_id_instruction=NOP_WORD, if_id_valid=0.
  - fetch_count=0, halted=0, state=RUN.
  - instruction_in is ignored until inflight_valid=1.
- Internal tracking:
  - inflight_pc <= pc every cycle (the address issued in the current cycle).
  - Invariant: inflight_pc equals the address whose data is on instruction_in in the following cycle.
- Per rising edge, in priority order:
  1. redirect=1 (overrides stall):
     - pc<=redirect_target, inflight_valid<=0.
     - IF/ID <= {pc=0, NOP_WORD, valid=0}.
  2. stall=1:
     - IF/ID holds.
     - If inflight_valid=1: pc<=inflight_pc (rewind to the pending instruction), inflight_valid<=0.
     - Else: pc holds, inflight_valid<=1.
  3. Otherwise:
     - IF/ID <= {inflight_pc, instruction_in, inflight_valid}.
     - pc<=pc+PC_STEP (16-bit wrap, 16'hFFFE -> 16'h0000).
     - inflight_valid<=1.
- fetch_count increments only in case 3 with inflight_valid=1.
- Latency:
  - Address issued in cycle t appears in IF/ID after the edge ending cycle t+1.
  - First valid IF/ID is two edges after reset release.
- Stall cost: the instruction is refetched, never lost or duplicated. A 1-cycle stall costs at most one extra bubble.
- Reset mid-operation: all state returns to reset values immediately, regardless of stall or redirect.
- States: RUN; HALTED (exists only with FETCH_HALT_EN).

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - RUN -> HALTED when case 3 writes a valid instruction with opcode 4'hF into IF/ID.
  - In HALTED:
    - pc holds, inflight_valid=0, halted=1.
    - IF/ID becomes a bubble on the next edge.
    - fetch_count frozen; stall is ignored.
  - redirect=1 in HALTED: -> RUN, halted=0, fetch resumes from redirect_target.
  - Only redirect or reset leaves HALTED.
- Undefined: opcode 4'hF is an ordinary instruction; halted tied to 0.

Test Plan:
- Reset then run, memory {0:1010, 2:1231, 4:145e, 6:167f} -> IF/ID sequence (0,1010), (2,1231), (4,145e), (6,167f), all valid; fetch_count=4; read_address steps 0,2,4,6,8.
- stall=1 for 3 cycles while if_id holds PC 2 -> IF/ID held at (2,1231); after release next valid entries are exactly (4,145e), (6,167f); no duplicates, no skips.
- redirect=1, target=0 while IF/ID holds PC 4 -> next IF/ID valid=0, instruction 0000; then (0,1010); no instruction from PC 6 ever valid.
- redirect=1 and stall=1 in the same cycle, target=4 -> redirect wins; bubble, then (4,145e).
- rst low mid-stream (pc=6) -> outputs reset immediately; after release, refetch from 0; fetch_count restarts at 0.
- FETCH_HALT_EN, memory 2:F000 -> IF/ID shows (2,F000), halted=1 next cycle, read_address frozen; redirect target=0 -> halted=0, (0,1010) follows.
